// File: rtl/ysyx2400012_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// request lengths and small decode helpers used by the LSU and its aligner.
package ysyx2400012_lsu_pkg;

    // funct3 encodings (stores reuse 0/1/2 for SB/SH/SW)
    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_LHU = 3'd5;

    // Request byte counts
    localparam int unsigned LEN_B = 1;
    localparam int unsigned LEN_H = 2;
    localparam int unsigned LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Access size comes from funct3[1:0]: 00 byte, 01 half, 1x word
    function automatic int unsigned access_len(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return LEN_B;
            2'b01:   return LEN_H;
            default: return LEN_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
        case (access_len(op))
            LEN_H:   return lo[0];
            LEN_W:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Keep only the low len bytes of store data
    function automatic logic [31:0] mask_wdata(input logic [2:0] op, input logic [31:0] wdata);
        case (access_len(op))
            LEN_B:   return {24'b0, wdata[7:0]};
            LEN_H:   return {16'b0, wdata[15:0]};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/ysyx2400012_load_align.sv
// Load aligner: picks the byte/halfword lane out of an aligned word and
// sign- or zero-extends it according to funct3.
//   word_i : aligned 32-bit read word
//   lane_i : byte address bits [1:0]
//   op_i   : funct3 of the load
//   data_o : extended load result
module ysyx2400012_load_align
    import ysyx2400012_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  op_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = word_i;
        case (op_i)
            OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            OP_LBU:  data_o = {24'b0, byte_sel};
            OP_LHU:  data_o = {16'b0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/ysyx2400012_lsu.sv
// Load/store unit: accepts one access at a time from execute, issues a single
// memory request (or reports misalignment directly), waits for the response
// with a timeout, and holds the extended result until writeback takes it.
//   in_*      : access from execute (valid/ready handshake)
//   mem_req_* : request to the data memory (valid/ready handshake)
//   mem_rsp_* : one-cycle response from memory (load data or store ack)
//   out_*     : result to writeback (valid/ready handshake), out_err on
//               misalignment or timeout
module ysyx2400012_lsu
    import ysyx2400012_lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic                  in_store,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_len,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,

    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_err
);

    localparam int unsigned CNT_W = 16;

    lsu_state_e            state_q;
    logic [2:0]            op_q;
    logic                  store_q;
    logic [1:0]            lane_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  req_valid_q;
    logic                  req_wen_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_len_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_rdata_q;
    logic                  out_err_q;

    logic [31:0]           align_data;

    ysyx2400012_load_align u_load_align (
        .word_i (32'(mem_rsp_rdata)),
        .lane_i (lane_q),
        .op_i   (op_q),
        .data_o (align_data)
    );

    assign in_ready      = (state_q == IDLE) && !reset;
    assign mem_req_valid = req_valid_q;
    assign mem_req_wen   = req_wen_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_len   = req_len_q;
    assign mem_req_wdata = req_wdata_q;
    assign out_valid     = out_valid_q;
    assign out_rdata     = out_rdata_q;
    assign out_err       = out_err_q;

    // Access FSM with registered request/result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 3'd0;
            store_q     <= 1'b0;
            lane_q      <= 2'd0;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            req_wen_q   <= 1'b0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
            req_wdata_q <= '0;
            out_valid_q <= 1'b0;
            out_rdata_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        store_q <= in_store;
                        lane_q  <= in_addr[1:0];
                        if (is_misaligned(in_op, in_addr[1:0])) begin
                            // Misaligned: no memory traffic, error straight to writeback
                            state_q     <= RESP;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b1;
                            out_rdata_q <= '0;
                        end else begin
                            state_q     <= REQ;
                            req_valid_q <= 1'b1;
                            req_wen_q   <= in_store;
                            if (in_store) begin
                                req_addr_q  <= in_addr;
                                req_len_q   <= DATA_WIDTH'(access_len(in_op));
                                req_wdata_q <= DATA_WIDTH'(mask_wdata(in_op, 32'(in_wdata)));
                            end else begin
                                // Loads always fetch the whole aligned word
                                req_addr_q  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
                                req_len_q   <= DATA_WIDTH'(LEN_W);
                                req_wdata_q <= '0;
                            end
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    // A response in the timeout cycle still wins
                    if (mem_rsp_valid) begin
                        state_q     <= RESP;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b0;
                        out_rdata_q <= store_q ? '0 : DATA_WIDTH'(align_data);
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        state_q     <= RESP;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b1;
                        out_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
